// File: rtl/lanectrl_pause_gen.sv
// Initiator for the lane-controller HS_IO_CLK_PAUSE handshake: pause, delay-load strobe, hold, gap.
// Define LANECTRL_PAUSE_MERGE_EN to chain a queued request straight from POST into LOAD.
module lanectrl_pause_gen #(
  parameter int unsigned PRE_CYCLES  = 2,
  parameter int unsigned LOAD_CYCLES = 1,
  parameter int unsigned POST_CYCLES = 3,
  parameter int unsigned GAP_CYCLES  = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic pause_req_i,
  input  logic ovf_clr_i,
  output logic hs_io_clk_pause_o,
  output logic delay_load_o,
  output logic pause_done_o,
  output logic busy_o,
  output logic pending_o,
  output logic overflow_o
);

  typedef enum logic [2:0] {IDLE, PRE, LOAD, POST, GAP} state_e;

  localparam logic [7:0] PreReload  = 8'(PRE_CYCLES - 1);
  localparam logic [7:0] LoadReload = 8'(LOAD_CYCLES - 1);
  localparam logic [7:0] PostReload = 8'(POST_CYCLES - 1);
  localparam logic [7:0] GapReload  = 8'(GAP_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       pending_q, pending_d;
  logic       overflow_q, overflow_d;
  logic       pause_q, load_q, done_q, busy_q;
  logic       done_d, consume, ovf_set, expired;

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != 8'd0) ? cnt_q - 8'd1 : 8'd0;
    done_d  = 1'b0;
    consume = 1'b0;
    expired = (cnt_q == 8'd0);
    unique case (state_q)
      // A request that landed on the final GAP edge waits here one cycle as pending.
      IDLE: if (pause_req_i || pending_q) begin
        state_d = PRE;
        cnt_d   = PreReload;
        consume = pending_q;
      end
      PRE: if (expired) begin
        state_d = LOAD;
        cnt_d   = LoadReload;
      end
      LOAD: if (expired) begin
        state_d = POST;
        cnt_d   = PostReload;
      end
      POST: if (expired) begin
        done_d = 1'b1;
`ifdef LANECTRL_PAUSE_MERGE_EN
        if (pending_q) begin
          state_d = LOAD;
          cnt_d   = LoadReload;
          consume = 1'b1;
        end else begin
          state_d = GAP;
          cnt_d   = GapReload;
        end
`else
        state_d = GAP;
        cnt_d   = GapReload;
`endif
      end
      GAP: if (expired) begin
        if (pending_q) begin
          state_d = PRE;
          cnt_d   = PreReload;
          consume = 1'b1;
        end else begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // A request arriving on the consuming edge refills the slot instead of overflowing.
  always_comb begin
    pending_d = pending_q;
    ovf_set   = 1'b0;
    if (consume) begin
      pending_d = pause_req_i;
    end else if (pause_req_i && (state_q != IDLE)) begin
      if (pending_q) ovf_set = 1'b1;
      else           pending_d = 1'b1;
    end
    overflow_d = ovf_set | (overflow_q & ~ovf_clr_i);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      pending_q  <= 1'b0;
      overflow_q <= 1'b0;
      pause_q    <= 1'b0;
      load_q     <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      pause_q    <= (state_d == PRE) || (state_d == LOAD) || (state_d == POST);
      load_q     <= (state_d == LOAD);
      done_q     <= done_d;
      busy_q     <= (state_d != IDLE);
    end
  end

  assign hs_io_clk_pause_o = pause_q;
  assign delay_load_o      = load_q;
  assign pause_done_o      = done_q;
  assign busy_o            = busy_q;
  assign pending_o         = pending_q;
  assign overflow_o        = overflow_q;

endmodule

// File: tb/tb_lanectrl_pause_gen.sv
// Bench for lanectrl_pause_gen: vector table, directed corner sequences and random traffic
// checked against a timeline model built from sequence start times.
module tb_lanectrl_pause_gen;

  localparam int PRE  = 2;
  localparam int LOAD = 1;
  localparam int POST = 3;
  localparam int GAP  = 2;
  localparam int T    = PRE + LOAD + POST;
`ifdef LANECTRL_PAUSE_MERGE_EN
  localparam bit MERGE = 1'b1;
`else
  localparam bit MERGE = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, pauseReq, ovfClr;
  logic pauseOut, loadOut, doneOut, busyOut, pendOut, ovfOut;

  int total = 0;
  int bad   = 0;

  // Model state: a sequence is described by the edge it was launched on.
  int edgeN  = 0;
  int mStart = 0;
  bit mActive, mPend, mOvf, mDone;
  logic [5:0] mExp;

  lanectrl_pause_gen dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .pause_req_i      (pauseReq),
    .ovf_clr_i        (ovfClr),
    .hs_io_clk_pause_o(pauseOut),
    .delay_load_o     (loadOut),
    .pause_done_o     (doneOut),
    .busy_o           (busyOut),
    .pending_o        (pendOut),
    .overflow_o       (ovfOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic req;
    logic clr;
    logic rst;
    logic [5:0] exp;   // {pause, load, done, busy, pending, overflow}
  } vec_t;

  vec_t vecs [10];

  task automatic modelStep(input bit req, input bit clr, input bit rst);
    bit consume;
    bit setOvf;
    int ph;
    int p;
    consume = 1'b0;
    setOvf  = 1'b0;
    if (rst) begin
      mActive = 1'b0;
      mPend   = 1'b0;
      mOvf    = 1'b0;
      mDone   = 1'b0;
    end else begin
      ph    = edgeN - mStart;
      mDone = mActive && (ph == T);
      if (!mActive) begin
        if (req || mPend) begin
          mActive = 1'b1;
          mStart  = edgeN;
          consume = mPend;
        end
      end else begin
        if (MERGE && (ph == T) && mPend) begin
          mStart  = edgeN - PRE;
          consume = 1'b1;
        end else if (ph == T + GAP) begin
          if (mPend) begin
            mStart  = edgeN;
            consume = 1'b1;
          end else begin
            mActive = 1'b0;
          end
        end
        if (!consume && req) begin
          if (mPend) setOvf = 1'b1;
          else       mPend  = 1'b1;
        end
      end
      if (consume) mPend = req;
      mOvf = setOvf | (mOvf & !clr);
    end
    p = edgeN + 1 - mStart;
    mExp[5] = mActive && (p >= 1) && (p <= T);
    mExp[4] = mActive && (p > PRE) && (p <= PRE + LOAD);
    mExp[3] = mDone;
    mExp[2] = mActive && (p >= 1) && (p <= T + GAP);
    mExp[1] = mPend;
    mExp[0] = mOvf;
    edgeN++;
  endtask

  task automatic checkOutput(input string name, input logic [5:0] expv);
    logic [5:0] act;
    act = {pauseOut, loadOut, doneOut, busyOut, pendOut, ovfOut};
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s edge=%0d got=%b expected=%b", name, edgeN - 1, act, expv);
    end
    total++;
    if (loadOut && !pauseOut) begin
      bad++;
      $display("[TB] FAIL %s_loadWithoutPause edge=%0d got=1 expected=0", name, edgeN - 1);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic clr, input logic rst, input string name);
    pauseReq = req;
    ovfClr   = clr;
    reset    = rst;
    @(posedge clk);
    modelStep(req, clr, rst);
    #1;
    checkOutput(name, mExp);
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 1'b1, "reset");
  endtask

  initial begin
    pauseReq = 1'b0;
    ovfClr   = 1'b0;
    reset    = 1'b1;

    // Single pulse: pause cycles 1-6, load 3, done 7, busy 1-8, idle at 9.
    vecs[0] = '{1'b0, 1'b0, 1'b1, 6'b000000};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 6'b100100};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 6'b100100};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 6'b110100};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 6'b100100};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 6'b100100};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 6'b100100};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 6'b001100};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 6'b000100};
    vecs[9] = '{1'b0, 1'b0, 1'b0, 6'b000000};

    doReset();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].req, vecs[i].clr, vecs[i].rst, "table_model");
      checkOutput("table_vector", vecs[i].exp);
    end

    // Two requests at 0 and 2: queued, then served after the gap (or merged).
    doReset();
    for (int e = 0; e < 20; e++)
      applyStimulus(e == 0 || e == 2, 1'b0, 1'b0, "twoReq");

    // Three requests: third overflows; clear at 10; later clear coincides with a new drop.
    doReset();
    for (int e = 0; e < 30; e++)
      applyStimulus(e == 0 || e == 2 || e == 4 || e == 11 || e == 13 || e == 15,
                    e == 10 || e == 15, 1'b0, "overflow");

    // Reset in the middle of a sequence, then a fresh request.
    doReset();
    for (int e = 0; e < 16; e++)
      applyStimulus(e == 0 || e == 6, 1'b0, e == 4, "midReset");

    // Request on the last gap edge while pending is being consumed.
    doReset();
    for (int e = 0; e < 26; e++)
      applyStimulus(e == 0 || e == 2 || e == 8, 1'b0, 1'b0, "lastGapReq");

    // Request on the last gap edge with nothing pending.
    doReset();
    for (int e = 0; e < 20; e++)
      applyStimulus(e == 0 || e == 8, 1'b0, 1'b0, "gapEdgeIdle");

    // Random traffic with occasional clears and resets.
    doReset();
    for (int e = 0; e < 3000; e++)
      applyStimulus($urandom_range(99) < 25, $urandom_range(99) < 8,
                    $urandom_range(999) < 8, "random");

    for (int e = 0; e < 30; e++)
      applyStimulus(1'b0, 1'b1, 1'b0, "drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lanectrl_pause_gen.md
Name: lanectrl_pause_gen

Overview:
- Initiator side of the lane-controller HS_IO_CLK_PAUSE interface.
- Driven by DDR PHY training/delay-update logic. For each update request, it asserts HS_IO_CLK_PAUSE with a programmable setup window, issues a DELAY_LOAD strobe while the clock is paused, holds the pause for a programmable window, then enforces a minimum unpaused gap.
- Its output feeds the lane pause synchroniser on the lane-control side.
- Buffers one pending request; flags overflow.

Parameters:
- PRE_CYCLES, 2, cycles HS_IO_CLK_PAUSE is high before DELAY_LOAD (legal 1..255)
- LOAD_CYCLES, 1, DELAY_LOAD pulse width in cycles (legal 1..255)
- POST_CYCLES, 3, cycles pause is held after DELAY_LOAD drops (legal 1..255)
- GAP_CYCLES, 2, minimum cycles pause is low between sequences (legal 1..255)

Ports:
- CLK  in  1  fabric clock, the same clock that feeds the lane pause synchroniser
- RESET  in  1  synchronous, active-high reset
- PAUSE_REQ  in  1  request a pause/load sequence; sampled every rising edge
- OVF_CLR  in  1  clears OVERFLOW
- HS_IO_CLK_PAUSE  out  1  registered pause request to lane control
- DELAY_LOAD  out  1  registered strobe to apply delay/direction update
- PAUSE_DONE  out  1  one-cycle pulse when a sequence's pause completes
- BUSY  out  1  sequence or gap in progress
- PENDING  out  1  one request queued
- OVERFLOW  out  1  sticky: request dropped

Behaviour:
- Clock and reset: single clock CLK; RESET is synchronous, active-high.
- Reset state: on a rising edge with RESET=1, all outputs are 0, state is IDLE, counters are 0 and pending is 0. This applies mid-sequence too: pause and load drop on that edge, with no DONE pulse.
- Outputs: all registered.
- Counter: one 8-bit down-counter reloaded on each state entry.
- States: IDLE, PRE, LOAD, POST, GAP.
- Timing: let T = PRE_CYCLES + LOAD_CYCLES + POST_CYCLES. If PAUSE_REQ is sampled high in IDLE at edge n:
  - HS_IO_CLK_PAUSE = 1 in cycles n+1 .. n+T.
  - DELAY_LOAD = 1 in cycles n+PRE_CYCLES+1 .. n+PRE_CYCLES+LOAD_CYCLES.
  - PAUSE_DONE = 1 in cycle n+T+1 only (pause already 0).
  - GAP occupies cycles n+T+1 .. n+T+GAP_CYCLES.
  - BUSY = 1 in cycles n+1 .. n+T+GAP_CYCLES.
- State transitions:
  - IDLE->PRE on PAUSE_REQ.
  - PRE->LOAD, LOAD->POST and POST->GAP when the counter expires.
  - GAP->IDLE when the counter expires and pending = 0.
  - GAP->PRE when the counter expires and pending = 1. Pending clears and BUSY stays 1.
- Invariant: DELAY_LOAD is never high unless HS_IO_CLK_PAUSE is high in the same cycle.
- Queuing:
  - PAUSE_REQ sampled while BUSY = 1 (or on the IDLE->PRE edge, no) with pending = 0 sets pending.
  - PAUSE_REQ sampled while pending = 1 and pending is not being consumed that edge is dropped and sets OVERFLOW.
  - Simultaneous consume (last GAP cycle) and new PAUSE_REQ: pending stays 1, no overflow.
- PAUSE_REQ level handling: PAUSE_REQ held high continuously counts as one new request per sampling edge. Callers pulse it for one cycle.
- OVERFLOW: cleared by OVF_CLR. A set event on the same edge as OVF_CLR wins, so OVERFLOW = 1.
- PENDING output = pending register.

Optional Feature:
- Macro: LANECTRL_PAUSE_MERGE_EN.
- Defined: on the last POST cycle, if pending = 1, next state is LOAD. This skips GAP and PRE, keeps HS_IO_CLK_PAUSE high, pulses PAUSE_DONE for the completed request in the first cycle of the new LOAD, and clears pending. Overflow rules are unchanged.
- Undefined: no merge; pending is serviced only after GAP completes.

Test Plan:
- Defaults, one PAUSE_REQ pulse at edge 0 -> pause high cycles 1-6; DELAY_LOAD cycle 3; PAUSE_DONE cycle 7; BUSY 1-8; all 0 at cycle 9.
- Defaults, requests at edges 0 and 2 (no merge) -> PENDING high 3-8; second pause 9-14, load 11, DONE 15; pause low exactly cycles 7-8.
- Defaults, requests at 0, 2, 4 -> third request dropped; OVERFLOW = 1 from cycle 5. OVF_CLR at 10 clears it at 11. OVF_CLR coincident with a new overflow leaves it 1.
- RESET at edge 4 during the first sequence -> cycle 5 has all outputs 0; no DONE; a new request at 6 gives pause 7-12.
- Request exactly at the last GAP cycle (edge 8) with pending set -> sequence restarts at 9 and PENDING remains 1, without OVERFLOW.
- LANECTRL_PAUSE_MERGE_EN defined, requests at 0 and 2 -> pause high continuously 1-10; DELAY_LOAD at 3 and 7; PAUSE_DONE at 7 and 11.
